regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 integer register file between two writeback requesters: src0 (ALU/EX result) and src1 (load unit result).
- Round-robin arbitration with a valid/ready handshake per source; the winning write is registered and presented to the register file one cycle later.
- Optional scoreboard tracks in-flight destination registers so decode can stall on RAW hazards.

---
 rtl/regfile_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single write port of the integer register file between two
//   writeback requesters: src0 (ALU/EX result) and src1 (load unit result).
//   Arbitration is round-robin with a valid/ready handshake per source. The
//   winning write is registered and presented to the register file on the
//   following cycle. Writes to x0 are accepted but never reach the port.
//
//   Optional hazard scoreboard, enabled by defining WB_SCOREBOARD_EN:
//   a 2^AW-bit busy bitmap of in-flight destination registers, queried
//   combinationally by decode. When the macro is undefined no bitmap exists,
//   rs1_busy/rs2_busy are constant 0, and the scoreboard inputs are ignored.
//   The port list is identical in both builds.
//
// Parameters:
//   XLEN  writeback data width
//   AW    register address width (2^AW registers)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s0_valid/ready/addr/data src0 writeback request and grant
//   s1_valid/ready/addr/data src1 writeback request and grant
//   wr_en, rd_addr_out,      registered register file write port
//   rd_out
//   set_en, set_addr         decode reserves a destination register
//   flush                    clears every reservation
//   rs1_addr_q, rs2_addr_q   hazard queries
//   rs1_busy, rs2_busy       queried register has an outstanding write
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [AW-1:0]   s0_addr,
  input  logic [XLEN-1:0] s0_data,

  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [AW-1:0]   s1_addr,
  input  logic [XLEN-1:0] s1_data,

  output logic            wr_en,
  output logic [AW-1:0]   rd_addr_out,
  output logic [XLEN-1:0] rd_out,

  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            flush,
  input  logic [AW-1:0]   rs1_addr_q,
  input  logic [AW-1:0]   rs2_addr_q,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  localparam int NREG = 1 << AW;

  // Source that won the most recent accepted transfer: 0 = src0, 1 = src1.
  // Resetting to 1 makes src0 win the first contention.
  logic            rr_last;

  logic            grant0;
  logic            grant1;
  logic            accept;
  logic [AW-1:0]   acc_addr;
  logic [XLEN-1:0] acc_data;
  logic            acc_real;

  // ---------------------------------------------------------------------------
  // Grant: combinational from the valids and rr_last. Under contention the
  // source that did not win last time is granted, so no source ever waits
  // more than one cycle. At most one grant is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (s0_valid && s1_valid) begin
      grant0 = rr_last;
      grant1 = !rr_last;
    end else begin
      grant0 = s0_valid;
      grant1 = s1_valid;
    end
  end

  assign s0_ready = grant0;
  assign s1_ready = grant1;

  assign accept   = grant0 | grant1;
  assign acc_addr = grant1 ? s1_addr : s0_addr;
  assign acc_data = grant1 ? s1_data : s0_data;
  // An accepted x0 write completes the handshake but is dropped here.
  assign acc_real = accept && (acc_addr != '0);

  // ---------------------------------------------------------------------------
  // Grant state and registered write port. A reset discards any write that
  // was accepted on the previous cycle. Address/data only move on a real
  // write and hold otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      rr_last     <= 1'b1;
      wr_en       <= 1'b0;
      rd_addr_out <= '0;
      rd_out      <= '0;
    end else begin
      wr_en <= acc_real;
      if (accept) begin
        rr_last <= grant1;
      end
      if (acc_real) begin
        rd_addr_out <= acc_addr;
        rd_out      <= acc_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  // ---------------------------------------------------------------------------
  // Busy bitmap. Priority, lowest to highest: commit clear, reservation set
  // (a newer producer outlives the older commit), flush. Bit 0 never sets.
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (wr_en) begin
      busy_next[rd_addr_out] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      busy_next[set_addr] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: the bitmap is plain flops, not a RAM, so it is reset along with
    // the rest of the state; stale reservations after reset would stall decode.
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign rs1_busy = busy[rs1_addr_q];
  assign rs2_busy = busy[rs2_addr_q];
`else
  // Scoreboard disabled: inputs are consumed only to keep them visibly unused.
  logic unused_sb;
  assign unused_sb = ^{set_en, set_addr, flush, rs1_addr_q, rs2_addr_q};
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter. Each cycle the bench predicts the
// grant from its own round-robin model, pushes the expected write-port state
// for the next cycle onto a queue, and pops/compares it after the clock edge.
// Scoreboard expectations follow WB_SCOREBOARD_EN (busy=0 when undefined).
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            s0_valid, s1_valid;
  logic            s0_ready, s1_ready;
  logic [AW-1:0]   s0_addr, s1_addr;
  logic [XLEN-1:0] s0_data, s1_data;
  logic            wr_en;
  logic [AW-1:0]   rd_addr_out;
  logic [XLEN-1:0] rd_out;
  logic            set_en;
  logic [AW-1:0]   set_addr;
  logic            flush;
  logic [AW-1:0]   rs1_addr_q, rs2_addr_q;
  logic            rs1_busy, rs2_busy;

  int total = 0;
  int bad   = 0;

  exp_t            sb_q[$];
  logic            m_rr;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  logic [XLEN-1:0] tb_rf [1<<AW];

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wr_en(wr_en), .rd_addr_out(rd_addr_out), .rd_out(rd_out),
    .set_en(set_en), .set_addr(set_addr), .flush(flush),
    .rs1_addr_q(rs1_addr_q), .rs2_addr_q(rs2_addr_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs: predict grant and the
  // resulting write, then compare the registered write port after the edge.
  task automatic cyc();
    logic g0, g1;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    exp_t e;
    #1;
    g0 = s0_valid && (!s1_valid || m_rr);
    g1 = s1_valid && (!s0_valid || !m_rr);
    check("s0_ready", s0_ready, g0);
    check("s1_ready", s1_ready, g1);
    if (rst) begin
      e.we = 1'b0; m_addr = '0; m_data = '0; m_rr = 1'b1;
    end else if (g0 || g1) begin
      a = g1 ? s1_addr : s0_addr;
      d = g1 ? s1_data : s0_data;
      e.we = (a != '0);
      if (a != '0) begin m_addr = a; m_data = d; end
      m_rr = g1;
    end else begin
      e.we = 1'b0;
    end
    e.addr = m_addr;
    e.data = m_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("wr_en", wr_en, e.we);
    check("rd_addr_out", rd_addr_out, e.addr);
    check("rd_out", rd_out, e.data);
    if (wr_en) tb_rf[rd_addr_out] = rd_out;
  endtask

  task automatic idle();
    s0_valid = 1'b0; s1_valid = 1'b0; set_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    m_rr = 1'b1; m_addr = '0; m_data = '0;
    foreach (tb_rf[i]) tb_rf[i] = '0;
    idle();
    s0_addr = '0; s0_data = '0; s1_addr = '0; s1_data = '0;
    set_addr = '0; rs1_addr_q = '0; rs2_addr_q = '0;

    // Reset state
    do_reset();
    check("reset_wr_en", wr_en, 1'b0);
    check("reset_rs1_busy", rs1_busy, 1'b0);

    // s0 alone: addr 5, data DEADBEEF for one cycle
    s0_valid = 1'b1; s0_addr = 5; s0_data = 32'hDEADBEEF;
    cyc();
    check("s0_only_addr", rd_addr_out, 5);
    check("s0_only_data", rd_out, 32'hDEADBEEF);
    idle();
    cyc();
    check("s0_only_after", wr_en, 1'b0);
    cyc();

    // Contention for 4 cycles after reset: s0,s1,s0,s1
    do_reset();
    s0_valid = 1'b1; s0_addr = 3; s0_data = 32'h11;
    s1_valid = 1'b1; s1_addr = 4; s1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("contend_addr", rd_addr_out, (i % 2 == 0) ? 3 : 4);
    end
    idle();
    cyc();

    // Same destination, first contention after reset: 0xA then 0xB
    do_reset();
    s0_valid = 1'b1; s0_addr = 7; s0_data = 32'hA;
    s1_valid = 1'b1; s1_addr = 7; s1_data = 32'hB;
    cyc();
    check("same_dst_first", rd_out, 32'hA);
    s0_valid = 1'b0;
    cyc();
    idle();
    cyc();
    check("same_dst_final", tb_rf[7], 32'hB);

    // x0 write from s1 is granted but never written
    s1_valid = 1'b1; s1_addr = 0; s1_data = 32'hFFFF;
    cyc();
    check("x0_no_write", wr_en, 1'b0);
    idle();
    cyc();

    // Reset mid-stream discards the pending write; grant state restarts at s0
    s1_valid = 1'b1; s1_addr = 2; s1_data = 32'h77;
    cyc();
    s1_valid = 1'b0;
    s0_valid = 1'b1; s0_addr = 9; s0_data = 32'h99;
    cyc();
    check("pre_rst_addr", rd_addr_out, 9);
    s0_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_wr_en", wr_en, 1'b0);
    check("mid_rst_addr", rd_addr_out, 0);
    s0_valid = 1'b1; s0_addr = 3; s0_data = 32'h33;
    s1_valid = 1'b1; s1_addr = 4; s1_data = 32'h44;
    #1;
    check("post_rst_s0_first", s0_ready, 1'b1);
    cyc();
    idle();
    cyc();

    // Scoreboard: reserve 12, then query
    set_en = 1'b1; set_addr = 12;
    cyc();
    set_en = 1'b0; rs1_addr_q = 12;
    #1;
    check("sb_set", rs1_busy, SB);
    // s1 commits 12: still busy while wr_en is high, clear the cycle after
    s1_valid = 1'b1; s1_addr = 12; s1_data = 32'h55;
    cyc();
    check("sb_commit_wr", rs1_busy, SB);
    s1_valid = 1'b0;
    cyc();
    check("sb_cleared", rs1_busy, 1'b0);
    // Set and commit of 12 in the same cycle: set wins
    s0_valid = 1'b1; s0_addr = 12; s0_data = 32'h66;
    cyc();
    s0_valid = 1'b0; set_en = 1'b1; set_addr = 12;
    cyc();
    set_en = 1'b0;
    check("sb_set_wins", rs1_busy, SB);
    // x0 is never busy; another register via rs2
    set_en = 1'b1; set_addr = 0;
    cyc();
    set_addr = 20;
    cyc();
    set_en = 1'b0; rs2_addr_q = 0;
    #1;
    check("sb_x0", rs2_busy, 1'b0);
    rs2_addr_q = 20;
    #1;
    check("sb_rs2", rs2_busy, SB);
    // Flush beats a simultaneous set
    flush = 1'b1; set_en = 1'b1; set_addr = 5;
    cyc();
    idle();
    check("sb_flush_rs1", rs1_busy, 1'b0);
    check("sb_flush_rs2", rs2_busy, 1'b0);
    rs1_addr_q = 5;
    #1;
    check("sb_flush_set", rs1_busy, 1'b0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
